// File: rtl/sweep_seq_if.sv
// rtl/sweep_seq_if.sv - direct-word write bus from the sweep sequencer to the DDS register stage
interface sweep_seq_if;
    logic        param_wen;
    logic [31:0] direct_fword;
    logic [31:0] direct_pword;
    logic [31:0] direct_amp;
    logic [2:0]  direct_en;

    modport master (
        output param_wen,
        output direct_fword,
        output direct_pword,
        output direct_amp,
        output direct_en
    );

    modport slave (
        input param_wen,
        input direct_fword,
        input direct_pword,
        input direct_amp,
        input direct_en
    );
endinterface

// File: rtl/sweep_seq.sv
// rtl/sweep_seq.sv - frequency-sweep sequencer: load, settle, dwell per point, optional looping
module sweep_seq #(
    parameter int PTS_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_wen,
    input  logic [31:0]      cfg_start_fword,
    input  logic [31:0]      cfg_step_fword,
    input  logic [PTS_W-1:0] cfg_num_points,
    input  logic [CNT_W-1:0] cfg_settle,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic [31:0]      cfg_pword,
    input  logic [31:0]      cfg_amp,
    input  logic             cfg_continuous,
    input  logic             start,
    input  logic             abort,
    sweep_seq_if.master      dds,
    output logic             meas_gate,
    output logic [PTS_W-1:0] point_idx,
    output logic             point_done,
    output logic             sweep_done,
    output logic             busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      start_fword_q, start_fword_d, step_fword_q, step_fword_d;
    logic [31:0]      pword_q, pword_d, amp_q, amp_d;
    logic [PTS_W-1:0] num_points_q, num_points_d;
    logic [CNT_W-1:0] settle_q, settle_d, dwell_q, dwell_d;
    logic             continuous_q, continuous_d;
    logic [31:0]      cur_fword_q, cur_fword_d;
    logic [PTS_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             param_wen_q, param_wen_d, meas_gate_q, meas_gate_d;
    logic             point_done_q, point_done_d, sweep_done_q, sweep_done_d;
    logic             busy_q, busy_d;
    logic [2:0]       direct_en_q, direct_en_d;
    logic [31:0]      direct_fword_q, direct_fword_d, direct_pword_q, direct_pword_d;
    logic [31:0]      direct_amp_q, direct_amp_d;
    logic [CNT_W-1:0] settle_len, dwell_len;
    logic             last_point;

    always_comb begin
        settle_len = (settle_q == '0) ? CNT_W'(1) : settle_q;
        dwell_len  = (dwell_q == '0) ? CNT_W'(1) : dwell_q;
        last_point = (idx_q == num_points_q - PTS_W'(1));

        start_fword_d = start_fword_q;
        step_fword_d  = step_fword_q;
        pword_d       = pword_q;
        amp_d         = amp_q;
        num_points_d  = num_points_q;
        settle_d      = settle_q;
        dwell_d       = dwell_q;
        continuous_d  = continuous_q;
        state_d       = state_q;
        cur_fword_d   = cur_fword_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;

        // Config is frozen for the duration of a sweep.
        if (cfg_wen && state_q == S_IDLE) begin
            start_fword_d = cfg_start_fword;
            step_fword_d  = cfg_step_fword;
            pword_d       = cfg_pword;
            amp_d         = cfg_amp;
            num_points_d  = cfg_num_points;
            settle_d      = cfg_settle;
            dwell_d       = cfg_dwell;
            continuous_d  = cfg_continuous;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && num_points_q != '0) begin
                        state_d     = S_LOAD;
                        cur_fword_d = start_fword_q;
                        idx_d       = '0;
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                    cnt_d   = settle_len - CNT_W'(1);
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_DWELL;
                        cnt_d   = dwell_len - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DWELL: begin
                    if (cnt_q == '0) state_d = S_NEXT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                S_NEXT: begin
                    if (!last_point) begin
                        state_d     = S_LOAD;
                        cur_fword_d = cur_fword_q + step_fword_q;
                        idx_d       = idx_q + PTS_W'(1);
                    end else if (continuous_q) begin
                        state_d     = S_LOAD;
                        cur_fword_d = start_fword_q;
                        idx_d       = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        param_wen_d    = (state_d == S_LOAD);
        meas_gate_d    = (state_d == S_DWELL);
        point_done_d   = (state_d == S_NEXT);
        sweep_done_d   = (state_d == S_NEXT) && last_point;
        busy_d         = (state_d != S_IDLE);
        direct_en_d    = busy_d ? 3'b111 : 3'b000;
        direct_fword_d = param_wen_d ? cur_fword_d : direct_fword_q;
        direct_pword_d = param_wen_d ? pword_q     : direct_pword_q;
        direct_amp_d   = param_wen_d ? amp_q       : direct_amp_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            start_fword_q  <= '0;
            step_fword_q   <= '0;
            pword_q        <= '0;
            amp_q          <= '0;
            num_points_q   <= '0;
            settle_q       <= '0;
            dwell_q        <= '0;
            continuous_q   <= 1'b0;
            cur_fword_q    <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            param_wen_q    <= 1'b0;
            meas_gate_q    <= 1'b0;
            point_done_q   <= 1'b0;
            sweep_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            direct_en_q    <= 3'b000;
            direct_fword_q <= '0;
            direct_pword_q <= '0;
            direct_amp_q   <= '0;
        end else begin
            state_q        <= state_d;
            start_fword_q  <= start_fword_d;
            step_fword_q   <= step_fword_d;
            pword_q        <= pword_d;
            amp_q          <= amp_d;
            num_points_q   <= num_points_d;
            settle_q       <= settle_d;
            dwell_q        <= dwell_d;
            continuous_q   <= continuous_d;
            cur_fword_q    <= cur_fword_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            param_wen_q    <= param_wen_d;
            meas_gate_q    <= meas_gate_d;
            point_done_q   <= point_done_d;
            sweep_done_q   <= sweep_done_d;
            busy_q         <= busy_d;
            direct_en_q    <= direct_en_d;
            direct_fword_q <= direct_fword_d;
            direct_pword_q <= direct_pword_d;
            direct_amp_q   <= direct_amp_d;
        end
    end

    assign dds.param_wen    = param_wen_q;
    assign dds.direct_fword = direct_fword_q;
    assign dds.direct_pword = direct_pword_q;
    assign dds.direct_amp   = direct_amp_q;
    assign dds.direct_en    = direct_en_q;
    assign meas_gate        = meas_gate_q;
    assign point_idx        = idx_q;
    assign point_done       = point_done_q;
    assign sweep_done       = sweep_done_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_sweep_seq.sv
// tb/tb_sweep_seq.sv - self-checking bench for sweep_seq against a per-cycle arithmetic sweep model
module tb_sweep_seq;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_wen;
    logic [31:0] cfg_start_fword, cfg_step_fword, cfg_pword, cfg_amp;
    logic [15:0] cfg_num_points;
    logic [31:0] cfg_settle, cfg_dwell;
    logic        cfg_continuous, start, abort;
    logic        meas_gate, point_done, sweep_done, busy;
    logic [15:0] point_idx;

    int tests  = 0;
    int failed = 0;

    sweep_seq_if dds_if ();

    sweep_seq dut (
        .clk(clk), .rstn(rstn), .cfg_wen(cfg_wen),
        .cfg_start_fword(cfg_start_fword), .cfg_step_fword(cfg_step_fword),
        .cfg_num_points(cfg_num_points), .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell),
        .cfg_pword(cfg_pword), .cfg_amp(cfg_amp), .cfg_continuous(cfg_continuous),
        .start(start), .abort(abort), .dds(dds_if),
        .meas_gate(meas_gate), .point_idx(point_idx), .point_done(point_done),
        .sweep_done(sweep_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_fw;
        logic [31:0] step_fw;
        int          npts;
        int          settle;
        int          dwell;
        logic [31:0] pword;
        logic [31:0] amp;
        int          exp_period;
        logic [31:0] exp_last;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [119:0] got, input logic [119:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [119:0] pack(input logic pw, input logic mg, input logic pd, input logic sd,
                                          input logic bz, input logic [2:0] en, input logic [15:0] idx,
                                          input logic [31:0] fw, input logic [31:0] pwd, input logic [31:0] am);
        return {pw, mg, pd, sd, bz, en, idx, fw, pwd, am};
    endfunction

    function automatic logic [119:0] observe();
        return pack(dds_if.param_wen, meas_gate, point_done, sweep_done, busy, dds_if.direct_en,
                    point_idx, dds_if.direct_fword, dds_if.direct_pword, dds_if.direct_amp);
    endfunction

    // Expected outputs c cycles after start was sampled: points tile time in blocks of 2+S+D.
    function automatic logic [119:0] model(input vec_t v, input logic cont, input int c);
        int s, d, p, rel, k, off, kk;
        s   = (v.settle == 0) ? 1 : v.settle;
        d   = (v.dwell == 0) ? 1 : v.dwell;
        p   = 2 + s + d;
        rel = c - 1;
        k   = rel / p;
        off = rel % p;
        if (!cont && k >= v.npts)
            return pack(0, 0, 0, 0, 0, 3'b000, 16'(v.npts - 1),
                        v.start_fw + v.step_fw * 32'(v.npts - 1), v.pword, v.amp);
        kk = cont ? (k % v.npts) : k;
        return pack(off == 0, (off >= 1 + s) && (off < 1 + s + d), off == p - 1,
                    (off == p - 1) && (kk == v.npts - 1), 1'b1, 3'b111, 16'(kk),
                    v.start_fw + v.step_fw * 32'(kk), v.pword, v.amp);
    endfunction

    task automatic program_cfg(input vec_t v, input logic cont);
        cfg_start_fword = v.start_fw;
        cfg_step_fword  = v.step_fw;
        cfg_num_points  = 16'(v.npts);
        cfg_settle      = 32'(v.settle);
        cfg_dwell       = 32'(v.dwell);
        cfg_pword       = v.pword;
        cfg_amp         = v.amp;
        cfg_continuous  = cont;
        cfg_wen         = 1'b1;
        tick();
        cfg_wen = 1'b0;
    endtask

    task automatic run_sweep(input vec_t v, input logic cont, input int ncyc, input int meddle_at,
                             input string name, output int n_pw, output int n_pd, output int n_sd,
                             output int n_gate, output int first_pw, output int period);
        program_cfg(v, cont);
        n_pw = 0; n_pd = 0; n_sd = 0; n_gate = 0; first_pw = -1; period = -1;
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start   = 1'b0;
            cfg_wen = 1'b0;
            if (c == meddle_at) begin
                cfg_start_fword = 32'hDEAD0000;
                cfg_num_points  = 16'd5;
                cfg_settle      = 32'd9;
                cfg_continuous  = ~cont;
                cfg_wen         = 1'b1;
                start           = 1'b1;
            end
            check(name, observe(), model(v, cont, c));
            if (dds_if.param_wen) begin
                if (first_pw < 0)    first_pw = c;
                else if (period < 0) period = c - first_pw;
                n_pw++;
            end
            if (point_done) n_pd++;
            if (sweep_done) n_sd++;
            if (meas_gate)  n_gate++;
        end
        start   = 1'b0;
        cfg_wen = 1'b0;
    endtask

    task automatic full_sweep(input vec_t v, input string name);
        int n_pw, n_pd, n_sd, n_gate, first_pw, period, d, p;
        d = (v.dwell == 0) ? 1 : v.dwell;
        p = 2 + ((v.settle == 0) ? 1 : v.settle) + d;
        run_sweep(v, 1'b0, v.npts * p + 2, 0, name, n_pw, n_pd, n_sd, n_gate, first_pw, period);
        check_int({name, "_wen_count"}, n_pw, v.npts);
        check_int({name, "_done_count"}, n_pd, v.npts);
        check_int({name, "_sweep_done"}, n_sd, 1);
        check_int({name, "_gate_cycles"}, n_gate, v.npts * d);
        check_int({name, "_first_wen"}, first_pw, 1);
        if (v.npts >= 2) check_int({name, "_period"}, period, v.exp_period);
        check({name, "_last_fword"}, {88'd0, dds_if.direct_fword}, {88'd0, v.exp_last});
        check_int({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_quiet(input string name, input int ncyc);
        logic [119:0] o;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            o = observe();
            check_int(name, int'(o[119:112]), 0);
        end
    endtask

    vec_t table_v[4];
    vec_t v;
    logic [119:0] o;
    int n_pw, n_pd, n_sd, n_gate, first_pw, period;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        table_v[0] = '{32'h01000000, 32'h00100000, 3, 2, 4, 32'h11111111, 32'h22222222, 8, 32'h01200000};
        table_v[1] = '{32'hFFFFFF00, 32'h00000200, 2, 3, 1, 32'h33333333, 32'h44444444, 6, 32'h00000100};
        table_v[2] = '{32'h00001234, 32'h00000010, 3, 0, 0, 32'h55555555, 32'h66666666, 4, 32'h00001254};
        table_v[3] = '{32'hABCD0000, 32'h00000001, 1, 1, 5, 32'h77777777, 32'h88888888, 8, 32'hABCD0000};

        rstn = 1'b0; cfg_wen = 1'b0; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0;
        cfg_start_fword = '0; cfg_step_fword = '0; cfg_pword = '0; cfg_amp = '0;
        cfg_num_points = '0; cfg_settle = '0; cfg_dwell = '0;
        tick();
        tick();
        check("reset", observe(), '0);
        rstn = 1'b1;
        tick();
        check("reset_release", observe(), '0);

        for (int i = 0; i < 4; i++) full_sweep(table_v[i], $sformatf("table%0d", i));

        // Abort in the first dwell cycle of point 1, then a clean rerun.
        v = table_v[0];
        program_cfg(v, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            check("abort_pre", observe(), model(v, 1'b0, c));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_next", observe(), pack(0, 0, 0, 0, 0, 3'b000, 16'd1, 32'h01100000, v.pword, v.amp));
        tick();
        check("abort_hold", observe(), pack(0, 0, 0, 0, 0, 3'b000, 16'd1, 32'h01100000, v.pword, v.amp));
        full_sweep(v, "after_abort");

        // Continuous with a config write and a start attempt mid-sweep.
        v = '{32'h10000000, 32'h01000000, 2, 1, 2, 32'h99999999, 32'hAAAAAAAA, 5, 32'h11000000};
        run_sweep(v, 1'b1, 22, 7, "cont", n_pw, n_pd, n_sd, n_gate, first_pw, period);
        check_int("cont_point_done", n_pd, 4);
        check_int("cont_sweep_done", n_sd, 2);
        check_int("cont_wen_count", n_pw, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        o = observe();
        check_int("cont_abort", int'(o[119:112]), 0);

        // Zero points: start is ignored.
        v = '{32'h00000001, 32'h1, 0, 1, 1, 32'h0, 32'h0, 0, 32'h0};
        program_cfg(v, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_quiet("npts0_quiet", 6);

        // Simultaneous start and abort in IDLE.
        program_cfg(table_v[0], 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_quiet("start_abort_quiet", 6);

        for (int r = 0; r < 20; r++) begin
            v.start_fw = $urandom;
            v.step_fw  = $urandom;
            v.npts     = int'($urandom_range(1, 4));
            v.settle   = int'($urandom_range(0, 4));
            v.dwell    = int'($urandom_range(0, 4));
            v.pword    = $urandom;
            v.amp      = $urandom;
            v.exp_period = 2 + ((v.settle == 0) ? 1 : v.settle) + ((v.dwell == 0) ? 1 : v.dwell);
            v.exp_last   = v.start_fw + v.step_fw * 32'(v.npts - 1);
            full_sweep(v, $sformatf("rand%0d", r));
        end

        // Reset in the middle of a sweep forces everything to 0.
        v = table_v[0];
        program_cfg(v, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            check("midreset_pre", observe(), model(v, 1'b0, c));
        end
        rstn = 1'b0;
        tick();
        check("midreset", observe(), '0);
        rstn = 1'b1;
        check_quiet("midreset_quiet", 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
